// File: rtl/scalar_wb_scheduler_if.sv
// Writeback request, decode-hazard query and register-file write port bundle.
// master = requesters/decode/regfile side, slave = scheduler.
interface scalar_wb_scheduler_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]      req_valid;
  logic [5*NREQ-1:0]    req_rd;
  logic [32*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 issue_valid;
  logic [4:0]           issue_rd;
  logic [4:0]           chk_rs1;
  logic [4:0]           chk_rs2;
  logic [4:0]           chk_rd;
  logic                 stall;
  logic                 WriteEn;
  logic [4:0]           rd;
  logic [31:0]          InputData;
  logic                 err_addr;

  modport master (
    output req_valid, req_rd, req_data, issue_valid, issue_rd, chk_rs1, chk_rs2, chk_rd,
    input  req_ready, stall, WriteEn, rd, InputData, err_addr
  );

  modport slave (
    input  req_valid, req_rd, req_data, issue_valid, issue_rd, chk_rs1, chk_rs2, chk_rd,
    output req_ready, stall, WriteEn, rd, InputData, err_addr
  );
endinterface

// File: rtl/scalar_wb_scheduler.sv
// Round-robin writeback arbiter with registered regfile write port and pending-register scoreboard.
// One-cycle write latency; requesters are only backpressured by losing arbitration or during reset.
module scalar_wb_scheduler #(
  parameter int NUM_REGS = 15,
  parameter int NREQ     = 3
) (
  input logic                  clk,
  input logic                  rst,
  scalar_wb_scheduler_if.slave wb
);

  localparam int         PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [5:0] NR = 6'(NUM_REGS);

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [31:0]     pending_q, pending_d;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic [4:0]      rd_q, rd_d;
  logic [31:0]     data_q, data_d;

  logic            gnt_vld;
  logic [PW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt_oh;
  logic [4:0]      gnt_rd;
  logic [31:0]     gnt_data;

  function automatic logic in_range(input logic [4:0] r);
    return (r != 5'd0) && ({1'b0, r} < NR);
  endfunction

  // Pass 0 covers indices above the pointer, pass 1 wraps around to the rest.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    gnt_oh   = '0;
    gnt_rd   = '0;
    gnt_data = '0;
    if (!rst) begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!gnt_vld && wb.req_valid[i] && ((p == 0) == (i > int'(ptr_q)))) begin
            gnt_vld   = 1'b1;
            gnt_idx   = PW'(i);
            gnt_oh[i] = 1'b1;
            gnt_rd    = wb.req_rd[5*i +: 5];
            gnt_data  = wb.req_data[32*i +: 32];
          end
        end
      end
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    pending_d = pending_q;
    we_d      = 1'b0;
    err_d     = 1'b0;
    rd_d      = rd_q;
    data_d    = data_q;
    if (gnt_vld) begin
      ptr_d  = gnt_idx;
      rd_d   = gnt_rd;
      data_d = gnt_data;
      we_d   = in_range(gnt_rd);
      err_d  = ({1'b0, gnt_rd} >= NR);
      if (in_range(gnt_rd)) begin
        pending_d[gnt_rd] = 1'b0;
      end
    end
    // Applied after the clear so a same-cycle reservation wins.
    if (wb.issue_valid && in_range(wb.issue_rd)) begin
      pending_d[wb.issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= PW'(NREQ - 1);
      pending_q <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      we_q      <= we_d;
      err_q     <= err_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
    end
  end

  // Gating with rst drops a write launched in the cycle right before reset.
  assign wb.req_ready = gnt_oh;
  assign wb.stall     = pending_q[wb.chk_rs1] | pending_q[wb.chk_rs2] | pending_q[wb.chk_rd];
  assign wb.WriteEn   = we_q & ~rst;
  assign wb.err_addr  = err_q & ~rst;
  assign wb.rd        = rd_q;
  assign wb.InputData = data_q;

endmodule
